// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM encodings, grant constants and defaults for wb_mem_arbiter
package wb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} arb_state_t;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0 = 2'b01;
    localparam logic [1:0] GNT_M1 = 2'b10;
    localparam int TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/wb_arb_rr2.sv
// wb_arb_rr2: two-way round-robin tenure FSM, grants held for a whole CYC-bounded bus cycle
module wb_arb_rr2 import wb_pkg::*; (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] hold,
    input  logic       abort,
    output logic [1:0] grant_o
);
    arb_state_t state, state_nxt;
    logic last, last_nxt;

    always_ff @(posedge clk_100MHz or posedge rst)
        if (rst) begin
            state <= IDLE;
            last <= 1'b1;
        end else begin
            state <= state_nxt;
            last <= last_nxt;
        end

    // last=1 means m1 was served last, so m0 wins the next tie
    always_comb begin
        state_nxt = state;
        last_nxt = last;
        case (state)
            IDLE: state_nxt = req[0] && (!req[1] || last) ? OWN_M0 : req[1] ? OWN_M1 : IDLE;
            OWN_M0: if (!hold[0] || abort) begin
                state_nxt = IDLE;
                last_nxt = 1'b0;
            end
            OWN_M1: if (!hold[1] || abort) begin
                state_nxt = IDLE;
                last_nxt = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_o = state == OWN_M0 ? GNT_M0 : state == OWN_M1 ? GNT_M1 : GNT_NONE;
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: CPU (m0) / display fetch (m1) Wishbone arbiter in front of the memory controller.
// Define ARB_WATCHDOG_EN to abort tenures whose slave never acknowledges.
module wb_mem_arbiter import wb_pkg::*; #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W = 9
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  grant_o
);
    logic [1:0] grant, req, abort_m;
    logic own_cyc, own_stb, abort;

    if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    wb_arb_rr2 u_rr (
        .clk_100MHz(clk_100MHz),
        .rst(rst),
        .req(req),
        .hold({m1_cyc_i, m0_cyc_i}),
        .abort(abort),
        .grant_o(grant)
    );

    assign grant_o = grant;
    assign own_cyc = (grant[0] & m0_cyc_i) | (grant[1] & m1_cyc_i);
    assign own_stb = (grant[0] & m0_cyc_i & m0_stb_i) | (grant[1] & m1_cyc_i & m1_stb_i);
    assign s_cyc_o = own_cyc & ~abort;
    assign s_stb_o = own_stb & ~abort;
    assign s_we_o = grant[0] ? m0_we_i : grant[1] & m1_we_i;
    assign s_sel_o = grant[0] ? m0_sel_i : grant[1] ? m1_sel_i : '0;
    assign s_adr_o = grant[0] ? m0_adr_i : grant[1] ? m1_adr_i : '0;
    assign s_dat_o = grant[0] ? m0_dat_i : grant[1] ? m1_dat_i : '0;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m0_ack_o = s_ack_i & grant[0];
    assign m1_ack_o = s_ack_i & grant[1];
    assign m0_err_o = abort_m[0];
    assign m1_err_o = abort_m[1];

`ifdef ARB_WATCHDOG_EN
    logic [CNT_W-1:0] cnt;
    logic [1:0] masked;

    assign abort = own_stb & ~s_ack_i & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign abort_m = grant & {2{abort}};
    assign req = {m1_cyc_i, m0_cyc_i} & ~masked;

    // an aborted master stays masked until it lets go of cyc
    always_ff @(posedge clk_100MHz or posedge rst)
        if (rst) begin
            cnt <= '0;
            masked <= '0;
        end else begin
            cnt <= (grant == GNT_NONE || s_ack_i) ? '0 : cnt + CNT_W'(own_stb);
            masked <= abort_m | (masked & {m1_cyc_i, m0_cyc_i});
        end
`else
    assign abort = 1'b0;
    assign abort_m = 2'b00;
    assign req = {m1_cyc_i, m0_cyc_i};
`endif
endmodule
